// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared combinational ALU: two requesters, one
// operation in flight, per-opcode execute time and a backpressured response register.
module alu_arbiter #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_opcode,
    input  logic        req0_cin,
    input  logic        req0_bin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_opcode,
    input  logic        req1_cin,
    input  logic        req1_bin,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_cin,
    output logic        alu_bin,
    output logic        alu_en,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_parity,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        rsp_err
);

    localparam int unsigned DATA_W     = 32;
    localparam logic [3:0]  OP_MUL     = 4'd9;
    localparam logic [3:0]  OP_DIV     = 4'd10;
    localparam logic [3:0]  OP_ILLEGAL = 4'd15;
    localparam logic [3:0]  MD_LOAD    = 4'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [3:0]          op_opc_q, op_opc_d;
    logic                op_cin_q, op_cin_d;
    logic                op_bin_q, op_bin_d;
    logic                op_id_q, op_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [4:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;

    logic                gnt0, gnt1, hs, sel_id;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [3:0]          sel_opc;
    logic                sel_cin, sel_bin;

    // Remaining EXEC cycles after the first one.
    function automatic logic [3:0] exec_count(input logic [3:0] opcode);
        if (opcode == OP_MUL || opcode == OP_DIV) begin
            return MD_LOAD;
        end
        return 4'd0;
    endfunction

    // Under contention the requester that did not win last time is served.
    always_comb begin
        gnt0       = req0_valid && (!req1_valid || last_grant_q);
        gnt1       = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == S_IDLE) && gnt0 && !rst;
        req1_ready = (state_q == S_IDLE) && gnt1 && !rst;
        hs         = req0_ready || req1_ready;
        sel_id     = req1_ready;
        sel_a      = sel_id ? req1_a      : req0_a;
        sel_b      = sel_id ? req1_b      : req0_b;
        sel_opc    = sel_id ? req1_opcode : req0_opcode;
        sel_cin    = sel_id ? req1_cin    : req0_cin;
        sel_bin    = sel_id ? req1_bin    : req0_bin;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_opc_d     = op_opc_q;
        op_cin_d     = op_cin_q;
        op_bin_d     = op_bin_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    op_a_d       = sel_a;
                    op_b_d       = sel_b;
                    op_opc_d     = sel_opc;
                    op_cin_d     = sel_cin;
                    op_bin_d     = sel_bin;
                    op_id_d      = sel_id;
                    last_grant_d = sel_id;
                    cnt_d        = exec_count(sel_opc);
                    if (sel_opc == OP_ILLEGAL) begin
                        // Illegal opcodes bypass the ALU entirely.
                        rsp_valid_d  = 1'b1;
                        rsp_id_d     = sel_id;
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = op_id_q;
                    rsp_result_d = alu_result;
                    rsp_flags_d  = {alu_parity, alu_overflow, alu_carry, alu_sign, alu_zero};
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_opc_q     <= '0;
            op_cin_q     <= 1'b0;
            op_bin_q     <= 1'b0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_opc_q     <= op_opc_d;
            op_cin_q     <= op_cin_d;
            op_bin_q     <= op_bin_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_en     = (state_q == S_EXEC);
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_opcode = op_opc_q;
    assign alu_cin    = op_cin_q;
    assign alu_bin    = op_bin_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, directed scenarios and a randomized
// run checked against a timestamp-based transaction model.
module tb_alu_arbiter;

    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin, req0_bin;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_opcode;
    logic        req1_valid, req1_ready, req1_cin, req1_bin;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_opcode;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_cin, alu_bin, alu_en;
    logic        alu_zero, alu_sign, alu_carry, alu_overflow, alu_parity;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic [36:0] alu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MULDIV_CYCLES(MD)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opcode(req0_opcode), .req0_cin(req0_cin), .req0_bin(req0_bin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opcode(req1_opcode), .req1_cin(req1_cin), .req1_bin(req1_bin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_bin(alu_bin), .alu_en(alu_en), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_parity(alu_parity), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Stand-in ALU; returns {parity, overflow, carry, sign, zero, result}.
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic cin, input logic bin);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = '0; w = '0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                w = {1'b0, a} - {1'b0, b} - {32'd0, bin};
                r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = ~a;
            4'd8:  r = b;
            4'd9:  r = a * b;
            4'd10: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd11: r = a + 32'd1;
            4'd12: r = a - 32'd1;
            4'd13: r = {a[15:0], a[31:16]};
            4'd14: r = b - a;
            default: r = a;
        endcase
        return {^r, v, c, r[31], (r == 32'd0), r};
    endfunction

    // When disabled the ALU presents junk, so a capture outside EXEC is visible.
    always_comb begin
        alu_out = alu_en ? alu_fn(alu_a, alu_b, alu_opcode, alu_cin, alu_bin)
                         : {5'b10101, 32'hDEAD_BEEF};
    end
    assign {alu_parity, alu_overflow, alu_carry, alu_sign, alu_zero, alu_result} = alu_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic ci, input logic bi);
        if (n == 0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; req0_cin = ci; req0_bin = bi;
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; req1_cin = ci; req1_bin = bi;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rst_alu_en got %b exp 0", alu_en); end
        checks++; if ({rsp_err, rsp_id, rsp_flags, rsp_result} !== 39'd0) begin
            errors++; $display("FAIL rst_rsp_regs got %b %b %h %h exp zeros", rsp_err, rsp_id, rsp_flags, rsp_result); end
        checks++; if ({alu_a, alu_b, alu_opcode, alu_cin, alu_bin} !== 70'd0) begin
            errors++; $display("FAIL rst_alu_drive got %h %h %h %b %b exp zeros", alu_a, alu_b, alu_opcode, alu_cin, alu_bin); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_idle got %b exp 000", {req0_ready, req1_ready, rsp_valid}); end
        tick();
        // A request during reset must not be accepted.
        rst = 1'b1;
        set_req(0, 4'd0, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        rst = 1'b0; req0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({alu_en, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL rst_priority got en=%b vld=%b exp 0 0", alu_en, rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_priority_rsp got %b exp 0", rsp_valid); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 4'd0, 32'd5, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({alu_en, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL single_exec got en=%b vld=%b exp 1 0", alu_en, rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_opcode} !== {32'd5, 32'd7, 4'd0}) begin
            errors++; $display("FAIL single_alu_ops got %h %h %h exp 5 7 0", alu_a, alu_b, alu_opcode); end
        tick();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_err, alu_en} !== 4'b1000) begin
            errors++; $display("FAIL single_rsp_ctl got %b exp 1000", {rsp_valid, rsp_id, rsp_err, alu_en}); end
        checks++; if ({rsp_result, rsp_flags} !== {32'd12, 5'b00000}) begin
            errors++; $display("FAIL single_rsp_data got %h %b exp 0000000c 00000", rsp_result, rsp_flags); end
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_clear got %b exp 0", rsp_valid); end
        tick();
    endtask

    task automatic test_contention();
        int got;
        do_reset();
        got = 0;
        set_req(0, 4'd4, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        set_req(1, 4'd4, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL cont_both_ready got 11 exp not both"); end
            if (rsp_valid) begin
                checks++; if (rsp_id !== 1'(got % 2)) begin
                    errors++; $display("FAIL cont_id #%0d got %b exp %0d", got, rsp_id, got % 2); end
                checks++; if (rsp_result !== 32'hFFFF_FFFF || rsp_flags[1] !== 1'b1) begin
                    errors++; $display("FAIL cont_data #%0d got %h %b exp ffffffff sign=1", got, rsp_result, rsp_flags); end
                got++;
            end
            tick();
        end
        checks++; if (got != 4) begin errors++; $display("FAIL cont_count got %0d exp 4", got); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_multicycle();
        int en_cnt, first;
        do_reset();
        en_cnt = 0; first = 0;
        set_req(1, 4'd9, 32'd6, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL mul_ready got %b exp 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (alu_en) en_cnt++;
            if (rsp_valid && first == 0) begin
                first = k;
                checks++; if ({rsp_id, rsp_err, rsp_result} !== {1'b1, 1'b0, 32'd42}) begin
                    errors++; $display("FAIL mul_rsp got id=%b err=%b %h exp 1 0 0000002a", rsp_id, rsp_err, rsp_result); end
            end
            tick();
        end
        checks++; if (en_cnt != MD) begin errors++; $display("FAIL mul_en_cycles got %0d exp %0d", en_cnt, MD); end
        checks++; if (first != MD + 1) begin errors++; $display("FAIL mul_latency got %0d exp %0d", first, MD + 1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, b0, a1, b1;
        logic [36:0] e0, e1;
        logic [38:0] snap;
        bit found;
        do_reset();
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        e0 = alu_fn(a0, b0, 4'd0, 1'b1, 1'b0);
        e1 = alu_fn(a1, b1, 4'd1, 1'b0, 1'b1);
        rsp_ready = 1'b0;
        set_req(0, 4'd0, a0, b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b exp 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        set_req(1, 4'd1, a1, b1, 1'b0, 1'b1);
        found = 0; snap = '0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_ready1 got %b exp 0", req1_ready); end
            if (rsp_valid) begin
                found = 1;
                snap = {rsp_id, rsp_err, rsp_flags, rsp_result};
            end
            tick();
        end
        checks++; if (!found || snap !== {1'b0, 1'b0, e0}) begin
            errors++; $display("FAIL bp_rsp got found=%0d %h exp %h", found, snap, {2'b00, e0}); end
        for (int k = 0; k < 5; k++) begin
            if (k == 4) rsp_ready = 1'b1;
            @(negedge clk);
            checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b1, snap}) begin
                errors++; $display("FAIL bp_hold #%0d got %b %h exp 1 %h", k, rsp_valid, {rsp_id, rsp_err, rsp_flags, rsp_result}, snap); end
            checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready1 #%0d got %b exp 0", k, req1_ready); end
            tick();
        end
        @(negedge clk);
        checks++; if ({req1_ready, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_accept got ready1=%b vld=%b exp 1 0", req1_ready, rsp_valid); end
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result} !== {3'b110, e1}) begin
            errors++; $display("FAIL bp_second_rsp got %b %b %h exp 1 1 %h", rsp_valid, rsp_id, {rsp_flags, rsp_result}, e1); end
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        set_req(0, 4'd15, $urandom, $urandom, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if ({req0_ready, alu_en} !== 2'b10) begin
            errors++; $display("FAIL ill_hs got ready=%b en=%b exp 1 0", req0_ready, alu_en); end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err, rsp_id, alu_en} !== 4'b1100) begin
            errors++; $display("FAIL ill_rsp_ctl got %b exp 1100", {rsp_valid, rsp_err, rsp_id, alu_en}); end
        checks++; if ({rsp_flags, rsp_result} !== 37'd0) begin
            errors++; $display("FAIL ill_rsp_data got %b %h exp 0 0", rsp_flags, rsp_result); end
        tick();
        @(negedge clk);
        checks++; if ({rsp_valid, alu_en} !== 2'b00) begin
            errors++; $display("FAIL ill_after got vld=%b en=%b exp 0 0", rsp_valid, alu_en); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        do_reset();
        set_req(0, 4'd9, 32'd123, 32'd456, 1'b0, 1'b0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL rme_exec got %b exp 1", alu_en); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, alu_en, rsp_err, rsp_id} !== 4'b0000) begin
            errors++; $display("FAIL rme_ctl got %b exp 0000", {rsp_valid, alu_en, rsp_err, rsp_id}); end
        checks++; if ({alu_a, alu_b, alu_opcode, rsp_result, rsp_flags} !== 105'd0) begin
            errors++; $display("FAIL rme_data got %h %h %h %h %b exp zeros", alu_a, alu_b, alu_opcode, rsp_result, rsp_flags); end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rme_no_rsp got rsp_valid=1 exp 0"); end
        tick();
        set_req(0, 4'd0, 32'd100, 32'd23, 1'b0, 1'b0);
        set_req(1, 4'd0, 32'd1, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rme_contention got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd123}) begin
            errors++; $display("FAIL rme_next_rsp got %b %b %h exp 1 0 0000007b", rsp_valid, rsp_id, rsp_result); end
        tick();
    endtask

    // Model: one op at a time, response due a fixed number of cycles after its handshake,
    // block free again the cycle after the response is taken.
    task automatic test_random(input int ncyc);
        logic        v[2];
        logic [31:0] ra[2], rb[2];
        logic [3:0]  rop[2];
        logic        rci[2], rbi[2];
        bit          free, pend, lastg, pid, pill, g0, g1, e_en, e_vld;
        int          hs, due;
        logic [36:0] pexp;
        logic [31:0] pa;
        logic [3:0]  pop;
        do_reset();
        free = 1; pend = 0; lastg = 1; pid = 0; pill = 0; hs = 0; due = 0; pexp = '0; pa = '0; pop = '0;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; ra[n] = '0; rb[n] = '0; rop[n] = '0; rci[n] = 1'b0; rbi[n] = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && $urandom_range(2, 0) == 0) begin
                    v[n] = 1'b1; ra[n] = $urandom; rb[n] = $urandom;
                    rop[n] = ($urandom_range(7, 0) == 0) ? 4'd15 : 4'($urandom_range(14, 0));
                    rci[n] = 1'($urandom_range(1, 0)); rbi[n] = 1'($urandom_range(1, 0));
                end
            end
            req0_valid = v[0]; req0_a = ra[0]; req0_b = rb[0]; req0_opcode = rop[0]; req0_cin = rci[0]; req0_bin = rbi[0];
            req1_valid = v[1]; req1_a = ra[1]; req1_b = rb[1]; req1_opcode = rop[1]; req1_cin = rci[1]; req1_bin = rbi[1];
            rsp_ready = ($urandom_range(3, 0) != 0);
            g0 = free && v[0] && (!v[1] || lastg);
            g1 = free && v[1] && (!v[0] || !lastg);
            e_vld = pend && (c >= due);
            e_en = pend && !pill && (c > hs) && (c < due);
            @(negedge clk);
            checks++; if ({req0_ready, req1_ready} !== {g0, g1}) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, {req0_ready, req1_ready}, {g0, g1}); end
            checks++; if ({alu_en, rsp_valid} !== {e_en, e_vld}) begin
                errors++; $display("FAIL rnd_en_vld cyc %0d got %b exp %b", c, {alu_en, rsp_valid}, {e_en, e_vld}); end
            if (e_en) begin
                checks++; if ({alu_a, alu_opcode} !== {pa, pop}) begin
                    errors++; $display("FAIL rnd_alu_drive cyc %0d got %h %h exp %h %h", c, alu_a, alu_opcode, pa, pop); end
            end
            if (e_vld) begin
                checks++; if ({rsp_id, rsp_err, rsp_flags, rsp_result} !== {pid, pill, pexp}) begin
                    errors++; $display("FAIL rnd_rsp cyc %0d got %b %b %h exp %b %b %h", c, rsp_id, rsp_err,
                                       {rsp_flags, rsp_result}, pid, pill, pexp); end
            end
            if (g0 || g1) begin
                pid = g1; pend = 1; hs = c; free = 0; lastg = g1;
                pill = (rop[pid] == 4'd15); pa = ra[pid]; pop = rop[pid];
                pexp = pill ? 37'd0 : alu_fn(ra[pid], rb[pid], rop[pid], rci[pid], rbi[pid]);
                due = c + (pill ? 1 : ((rop[pid] == 4'd9 || rop[pid] == 4'd10) ? MD + 1 : 2));
                v[pid] = 1'b0;
            end else if (e_vld && rsp_ready) begin
                pend = 0; free = 1;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_opcode = '0; req0_cin = 1'b0; req0_bin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_opcode = '0; req1_cin = 1'b0; req1_bin = 1'b0;
        tick();
        tick();
        test_reset();
        test_single();
        test_contention();
        test_multicycle();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shared-access controller for the 32-bit ALU. It arbitrates round-robin between two requesters and drives the combinational ALU with registered operands. It holds the ALU enabled for a per-opcode execute time, then captures the result and flags into a response register held under backpressure. It sits between two issuing clients and one `alu` instance; the ALU has no clock, so this block provides all sequencing.

## Interface
- `MULDIV_CYCLES`, default 4: number of EXEC cycles for opcodes 9 (mul) and 10 (div). Legal range 1–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32 each: operands.
- `req0_opcode`, `req1_opcode` in 4 each: ALU opcode, 0–14 legal; 15 illegal.
- `req0_cin`, `req0_bin`, `req1_cin`, `req1_bin` in 1 each: carry-in and borrow-in.
- `alu_a`, `alu_b` out 32 each: operands to the ALU.
- `alu_opcode` out 4: opcode to the ALU.
- `alu_cin`, `alu_bin`, `alu_en` out 1 each: ALU controls.
- `alu_result` in 32: ALU result.
- `alu_zero`, `alu_sign`, `alu_carry`, `alu_overflow`, `alu_parity` in 1 each: ALU flags.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester index, 0 or 1.
- `rsp_result` out 32: captured result.
- `rsp_flags` out 5: {parity, overflow, carry, sign, zero}.
- `rsp_err` out 1: illegal opcode.

## Operation
- The FSM has three states.
- **IDLE**
  - Grant is combinational from the valids and `last_grant`.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not equal to `last_grant` is granted.
  - `reqN_ready` = grant to N, asserted only in IDLE.
  - On handshake, capture a, b, opcode, cin, bin and the id into the op register, set `last_grant` to the id, and load the counter.
  - Next state: EXEC, or RESP directly if opcode = 15.
- **EXEC**
  - `alu_en` = 1; `alu_*` driven from the op register.
  - Counter loaded with `MULDIV_CYCLES - 1` for opcodes 9 and 10, otherwise 0; it decrements each EXEC cycle.
  - On the edge where the counter is 0: capture `alu_result` and the five flags into the `rsp_*` registers, set `rsp_err` = 0, set `rsp_valid` = 1, and go to RESP.
- **RESP**
  - `rsp_*` outputs are held stable while `rsp_valid` && !`rsp_ready`.
  - When `rsp_ready` is high: clear `rsp_valid` and return to IDLE.
- **Illegal opcode 15**
  - The ALU is never enabled.
  - `rsp_result` = 0, `rsp_flags` = 0, `rsp_err` = 1.
  - The response appears one cycle after the handshake.
- **ALU drive outside EXEC:** `alu_en` = 0; `alu_a`, `alu_b`, `alu_opcode`, `alu_cin`, `alu_bin` keep the op-register values.
- **Outstanding operations:** one at a time; no request is accepted in EXEC or RESP.
- **Flag capture:** flags come from the ALU combinationally off the registered opcode; no recomputation in this block.

## Timing
- **Reset values:** FSM = IDLE; `rsp_valid`, `rsp_err`, `rsp_id`, `alu_en` = 0; `rsp_result`, `rsp_flags` = 0; op register = 0 (so `alu_*` outputs = 0); `last_grant` = 1, so requester 0 wins the first contention; counter = 0.
- **Handshake cycle T (IDLE):** `reqN_valid` && `reqN_ready`.
- **Single-cycle ops:** EXEC in cycle T+1; `rsp_valid` = 1 from T+2.
- **Mul/div:** EXEC during T+1 … T+`MULDIV_CYCLES`; `rsp_valid` from T+`MULDIV_CYCLES`+1.
- **Illegal opcode:** `rsp_valid` from T+1.
- **Throughput:**
  - With `rsp_ready` tied high, a single-cycle op takes 3 cycles: IDLE, EXEC, RESP.
  - Next handshake no earlier than the cycle after the `rsp_ready` handshake.
- **Requester-side obligations:** a valid requester holds its fields stable until ready.
- **Arbiter guarantees:**
  - `reqN_ready` never asserts outside IDLE.
  - Both readys are never asserted together.
- **Reset mid-operation:** `rst` in EXEC or RESP drops the in-flight op. The next cycle is IDLE with `rsp_valid` = 0, and no response is ever produced for that op.
- **`rst` has priority:** a handshake in the same cycle as `rst` is ignored.

## Test plan
- **Single request:**
  - Stimulus: req0 add, a=5, b=7, cin=0, with `rsp_ready` high.
  - Response: `rsp_valid` at T+2, `rsp_id`=0, `rsp_result`=12, `rsp_flags`=5'b00000, `rsp_err`=0.
- **Contention:**
  - Stimulus: req0 and req1 continuously valid, both xor, a=0xFFFF0000, b=0x0000FFFF, `rsp_ready` high.
  - Response: `rsp_id` sequence 0,1,0,1; each `rsp_result`=0xFFFFFFFF; sign flag=1.
- **Multicycle:**
  - Stimulus: `MULDIV_CYCLES`=4, req1 mul, a=6, b=7.
  - Response: `alu_en` high for exactly 4 cycles; `rsp_valid` at T+5; `rsp_result`=42; `rsp_id`=1.
- **Backpressure:**
  - Stimulus: `rsp_ready` low for 5 cycles after `rsp_valid`, with req1 valid the whole time.
  - Response: `rsp_*` stable throughout; `req1_ready` stays 0; req1 is accepted in the IDLE cycle right after the `rsp_ready` handshake.
- **Illegal opcode:**
  - Stimulus: req0 opcode 15.
  - Response: `alu_en` never 1; `rsp_valid` at T+1 with `rsp_err`=1, `rsp_result`=0.
- **Reset mid-EXEC:**
  - Stimulus: mul issued, `rst` pulsed in the second EXEC cycle.
  - Response: no `rsp_valid` for that op; outputs at reset values; the next request is served normally, with req0 winning contention.
